// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory channel among the IF read port, the MA read
// port and the MA write port with a registered req/ack handshake.
module mem_port_arbiter #(
   parameter int unsigned ADDR_L     = 32,
   parameter int unsigned DATA_L     = 32,
   parameter int unsigned LEN_L      = 2,
   parameter int unsigned STARVE_LIM = 4,
   parameter int unsigned CNT_L      = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r0_re,
   input  logic [ADDR_L-1:0] r0_addr,
   input  logic [LEN_L-1:0]  r0_len,
   output logic [DATA_L-1:0] r0_data,
   output logic              r0_ack,
   input  logic              r1_re,
   input  logic [ADDR_L-1:0] r1_addr,
   input  logic [LEN_L-1:0]  r1_len,
   output logic [DATA_L-1:0] r1_data,
   output logic              r1_ack,
   input  logic              w_we,
   input  logic [ADDR_L-1:0] w_addr,
   input  logic [LEN_L-1:0]  w_len,
   input  logic [DATA_L-1:0] w_data,
   output logic              w_ack,
   output logic              m_req,
   output logic              m_rw,
   output logic [ADDR_L-1:0] m_addr,
   output logic [LEN_L-1:0]  m_len,
   output logic [DATA_L-1:0] m_wdata,
   input  logic [DATA_L-1:0] m_rdata,
   input  logic              m_ack
);

   // state | meaning
   // IDLE  | no transaction; arbitrate among pending requests
   // BUSY  | m_req held, waiting for m_ack
   // DONE  | granted port's ack high for this one cycle
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] G_R0 = 2'd0;
   localparam logic [1:0] G_R1 = 2'd1;
   localparam logic [1:0] G_W  = 2'd2;
   localparam logic [CNT_L-1:0] LIM = CNT_L'(STARVE_LIM);

   state_t           state;
   logic [1:0]       gnt;
   logic [CNT_L-1:0] starve_cnt;
   logic             starved;
   logic [CNT_L-1:0] cnt_next;

   assign starved  = r0_re && (starve_cnt == LIM);
   // Counter only moves while port 0 is actually waiting behind a data grant
   assign cnt_next = !r0_re ? '0 :
                     (starve_cnt == LIM) ? LIM : starve_cnt + CNT_L'(1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         gnt        <= G_R0;
         starve_cnt <= '0;
         m_req      <= 1'b0;
         m_rw       <= 1'b0;
         m_addr     <= '0;
         m_len      <= '0;
         m_wdata    <= '0;
         r0_data    <= '0;
         r1_data    <= '0;
         r0_ack     <= 1'b0;
         r1_ack     <= 1'b0;
         w_ack      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (r0_re && (starved || !(w_we || r1_re))) begin
                  gnt        <= G_R0;
                  m_rw       <= 1'b0;
                  m_addr     <= r0_addr;
                  m_len      <= r0_len;
                  m_wdata    <= '0;
                  m_req      <= 1'b1;
                  starve_cnt <= '0;
                  state      <= BUSY;
               end else if (w_we) begin
                  gnt        <= G_W;
                  m_rw       <= 1'b1;
                  m_addr     <= w_addr;
                  m_len      <= w_len;
                  m_wdata    <= w_data;
                  m_req      <= 1'b1;
                  starve_cnt <= cnt_next;
                  state      <= BUSY;
               end else if (r1_re) begin
                  gnt        <= G_R1;
                  m_rw       <= 1'b0;
                  m_addr     <= r1_addr;
                  m_len      <= r1_len;
                  m_wdata    <= '0;
                  m_req      <= 1'b1;
                  starve_cnt <= cnt_next;
                  state      <= BUSY;
               end else begin
                  starve_cnt <= '0;
               end
            end
            BUSY: begin
               if (m_ack) begin
                  m_req <= 1'b0;
                  state <= DONE;
                  case (gnt)
                     G_R0: begin
                        r0_data <= m_rdata;
                        r0_ack  <= 1'b1;
                     end
                     G_R1: begin
                        r1_data <= m_rdata;
                        r1_ack  <= 1'b1;
                     end
                     default: w_ack <= 1'b1;
                  endcase
               end
            end
            DONE: begin
               r0_ack <= 1'b0;
               r1_ack <= 1'b0;
               w_ack  <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a scripted memory responder serves each
// grant and every observation is compared against hand-computed values.
module tb_mem_port_arbiter;

   localparam int ADDR_L = 32;
   localparam int DATA_L = 32;
   localparam int LEN_L  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              r0_re, r1_re, w_we;
   logic [ADDR_L-1:0] r0_addr, r1_addr, w_addr;
   logic [LEN_L-1:0]  r0_len, r1_len, w_len;
   logic [DATA_L-1:0] w_data;
   logic [DATA_L-1:0] r0_data, r1_data;
   logic              r0_ack, r1_ack, w_ack;
   logic              m_req, m_rw, m_ack;
   logic [ADDR_L-1:0] m_addr;
   logic [LEN_L-1:0]  m_len;
   logic [DATA_L-1:0] m_wdata, m_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_L(ADDR_L), .DATA_L(DATA_L), .LEN_L(LEN_L), .STARVE_LIM(4), .CNT_L(3)
   ) dut (
      .clk(clk), .rst(rst),
      .r0_re(r0_re), .r0_addr(r0_addr), .r0_len(r0_len), .r0_data(r0_data), .r0_ack(r0_ack),
      .r1_re(r1_re), .r1_addr(r1_addr), .r1_len(r1_len), .r1_data(r1_data), .r1_ack(r1_ack),
      .w_we(w_we), .w_addr(w_addr), .w_len(w_len), .w_data(w_data), .w_ack(w_ack),
      .m_req(m_req), .m_rw(m_rw), .m_addr(m_addr), .m_len(m_len), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_ack(m_ack)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] acks();
      return {w_ack, r1_ack, r0_ack};
   endfunction

   // Called at a negedge. Waits for a grant, holds m_ack off for 'delay'
   // cycles, completes it, drops the requests in 'drop' ({w,r1,r0}) once the
   // ack is seen, and returns at the following (IDLE) negedge.
   task automatic serve(input string tag, input int delay, input logic [31:0] rdata,
                        input logic exp_rw, input logic [31:0] exp_addr,
                        input logic [1:0] exp_len, input logic [31:0] exp_wdata,
                        input logic [2:0] exp_ack, input logic [2:0] drop);
      for (int i = 0; i < 50 && m_req !== 1'b1; i++) @(negedge clk);
      chk({tag, "_req"}, m_req, 1'b1);
      chk({tag, "_rw"}, m_rw, exp_rw);
      chk({tag, "_addr"}, m_addr, exp_addr);
      chk({tag, "_len"}, m_len, exp_len);
      if (exp_rw) chk({tag, "_wdata"}, m_wdata, exp_wdata);
      for (int d = 0; d < delay; d++) begin
         chk({tag, "_hold_req"}, m_req, 1'b1);
         chk({tag, "_hold_addr"}, m_addr, exp_addr);
         chk({tag, "_hold_rw"}, m_rw, exp_rw);
         chk({tag, "_hold_noack"}, acks(), 3'b000);
         @(negedge clk);
      end
      m_ack   = 1'b1;
      m_rdata = rdata;
      @(negedge clk);
      m_ack   = 1'b0;
      m_rdata = 32'h0;
      chk({tag, "_ack"}, acks(), exp_ack);
      chk({tag, "_req_drop"}, m_req, 1'b0);
      if (exp_ack == 3'b001) chk({tag, "_r0_data"}, r0_data, rdata);
      if (exp_ack == 3'b010) chk({tag, "_r1_data"}, r1_data, rdata);
      if (drop[0]) r0_re = 1'b0;
      if (drop[1]) r1_re = 1'b0;
      if (drop[2]) w_we  = 1'b0;
      @(negedge clk);
      chk({tag, "_ack_clr"}, acks(), 3'b000);
   endtask

   initial begin
      rst = 1'b0;
      r0_re = 0; r1_re = 0; w_we = 0; m_ack = 0;
      r0_addr = 0; r1_addr = 0; w_addr = 0;
      r0_len = 0; r1_len = 0; w_len = 0;
      w_data = 0; m_rdata = 0;
      repeat (3) @(negedge clk);
      chk("rst_m_req", m_req, 1'b0);
      chk("rst_acks", acks(), 3'b000);
      chk("rst_m_addr", m_addr, 32'h0);
      chk("rst_state", dut.state, 2'd0);
      rst = 1'b1;
      @(negedge clk);

      // single port 0 read, memory acks in first BUSY cycle
      r0_re = 1'b1; r0_addr = 32'h100; r0_len = 2'd1;
      @(negedge clk);
      chk("t1_req", m_req, 1'b1);
      chk("t1_rw", m_rw, 1'b0);
      chk("t1_addr", m_addr, 32'h100);
      chk("t1_len", m_len, 2'd1);
      m_ack = 1'b1; m_rdata = 32'hDEADBEEF;
      @(negedge clk);
      m_ack = 1'b0; m_rdata = 32'h0;
      chk("t1_ack", acks(), 3'b001);
      chk("t1_data", r0_data, 32'hDEADBEEF);
      chk("t1_req_low", m_req, 1'b0);
      r0_re = 1'b0;
      @(negedge clk);
      chk("t1_ack_clr", acks(), 3'b000);
      chk("t1_idle", dut.state, 2'd0);

      // all three at once: write, then port 1, then port 0
      w_we = 1'b1; w_addr = 32'h200; w_data = 32'h55; w_len = 2'd3;
      r1_re = 1'b1; r1_addr = 32'h300; r1_len = 2'd2;
      r0_re = 1'b1; r0_addr = 32'h400; r0_len = 2'd0;
      serve("sim_w", 2, 32'h0, 1'b1, 32'h200, 2'd3, 32'h55, 3'b100, 3'b100);
      serve("sim_r1", 2, 32'h11112222, 1'b0, 32'h300, 2'd2, 32'h0, 3'b010, 3'b010);
      serve("sim_r0", 2, 32'h33334444, 1'b0, 32'h400, 2'd0, 32'h0, 3'b001, 3'b001);

      // starvation: r0 held while r1 keeps requesting
      r0_re = 1'b1; r0_addr = 32'h700; r0_len = 2'd1;
      r1_re = 1'b1; r1_addr = 32'h800; r1_len = 2'd3;
      for (int i = 0; i < 4; i++)
         serve("starve_r1", 0, 32'h1000 + i, 1'b0, 32'h800, 2'd3, 32'h0, 3'b010, 3'b000);
      chk("starve_cnt_lim", dut.starve_cnt, 3'd4);
      serve("starve_r0", 0, 32'hA0A0A0A0, 1'b0, 32'h700, 2'd1, 32'h0, 3'b001, 3'b001);
      chk("starve_cnt_clr", dut.starve_cnt, 3'd0);
      serve("starve_tail", 0, 32'h2000, 1'b0, 32'h800, 2'd3, 32'h0, 3'b010, 3'b010);
      chk("starve_cnt_idle", dut.starve_cnt, 3'd0);

      // stall 20 cycles with a new write request arriving mid-transaction
      r1_re = 1'b1; r1_addr = 32'h340; r1_len = 2'd2;
      for (int i = 0; i < 10 && m_req !== 1'b1; i++) @(negedge clk);
      w_we = 1'b1; w_addr = 32'h500; w_data = 32'hAA; w_len = 2'd3;
      serve("stall", 20, 32'hCAFEF00D, 1'b0, 32'h340, 2'd2, 32'h0, 3'b010, 3'b010);
      serve("stall_w", 0, 32'h0, 1'b1, 32'h500, 2'd3, 32'hAA, 3'b100, 3'b100);

      // stray m_ack while idle
      m_ack = 1'b1; m_rdata = 32'h12345678;
      @(negedge clk);
      m_ack = 1'b0; m_rdata = 32'h0;
      chk("stray_acks", acks(), 3'b000);
      chk("stray_req", m_req, 1'b0);
      chk("stray_r0_data", r0_data, 32'hA0A0A0A0);
      chk("stray_r1_data", r1_data, 32'hCAFEF00D);
      @(negedge clk);
      chk("stray_acks2", acks(), 3'b000);

      // reset while BUSY, then re-arbitration of the held request
      r0_re = 1'b1; r0_addr = 32'h600; r0_len = 2'd1;
      for (int i = 0; i < 10 && m_req !== 1'b1; i++) @(negedge clk);
      chk("rb_busy", m_req, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      chk("rb_req", m_req, 1'b0);
      chk("rb_addr", m_addr, 32'h0);
      chk("rb_len", m_len, 2'd0);
      chk("rb_acks", acks(), 3'b000);
      chk("rb_r0_data", r0_data, 32'h0);
      chk("rb_r1_data", r1_data, 32'h0);
      chk("rb_state", dut.state, 2'd0);
      rst = 1'b1;
      serve("rearb", 1, 32'h600DD00D, 1'b0, 32'h600, 2'd1, 32'h0, 3'b001, 3'b001);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
